cdc_req_arbiter: RTL and testbench
==================================

// Module: cdc_req_arbiter
//
// PURPOSE
//   Round-robin arbiter that shares one clk_i-domain resource between NUM_REQ
//   requesters living in foreign or asynchronous clock domains.
//   Each requester drives a level request and runs a 4-phase req/ack handshake.
//   Every req_i is synchronised internally with a dual_flop_sync instance
//   (posedge fetch, posedge launch, no bypass).
//   Grants are issued one at a time to the shared resource; completion is reported via gnt_done_i.
//
// PARAMETERS
//   NUM_REQ            4  number of requesters; legal range 2..16
//   SYNC_MIDDLE_STAGE  0  1 = add a third synchroniser flop (MIDDLE_STAGE_EN); S = 2 + SYNC_MIDDLE_STAGE
//
// PORTS
//   clk_i        in   1                 resource-domain clock
//   arst_ni      in   1                 reset, asynchronous, active-low
//   req_i        in   NUM_REQ           async level requests (4-phase)
//   ack_o        out  NUM_REQ           level acks, registered, glitch-free
//   gnt_valid_o  out  1                 grant active to the shared resource
//   gnt_idx_o    out  $clog2(NUM_REQ)   index of granted requester; valid only while gnt_valid_o=1
//   gnt_done_i   in   1                 1-cycle pulse: resource finished the current grant
//   proto_err_o  out  1                 1-cycle pulse: requester withdrew req while granted
//
// BEHAVIOUR
//   Reset
//     - All outputs 0 and all synchroniser flops 0.
//     - Channels go to IDLE; the RR pointer last_q = NUM_REQ-1, so index 0 has first priority.
//   Reset mid-operation
//     - Clears everything immediately (asynchronous). No ack is issued for the aborted grant.
//     - A held req_i is re-arbitrated after reset release.
//   Synchronisation: req_s[i] = req_i[i] after S rising edges.
//   Per-channel FSM
//     - IDLE    (ack=0): pending when req_s=1.
//     - GRANTED (ack=0): entered on the edge the arbiter selects the channel.
//     - ACKED   (ack=1): GRANTED -> ACKED on the edge where gnt_done_i=1 and req_s=1.
//     - ACKED -> IDLE on the first edge with req_s=0; ack_o drops at that edge.
//     - An ACKED channel is never re-granted until it has returned to IDLE.
//   Arbiter FSM
//     - ARB_IDLE -> ARB_BUSY on an edge where at least one channel is pending.
//       That edge registers gnt_valid_o=1, gnt_idx_o=winner and last_q=winner.
//     - ARB_BUSY -> ARB_IDLE on the edge where gnt_done_i=1; gnt_valid_o=0 from that edge.
//     - At least one idle cycle separates consecutive grants (no back-to-back).
//   Winner selection
//     - Search starts at (last_q+1) mod NUM_REQ and wraps around.
//     - The first pending index found is granted.
//   Latency
//     - req_i high before edge 0 -> req_s high after edge S-1 -> gnt_valid_o high after edge S.
//     - With S=2: granted after 3 edges. Ack deassertion takes the same S+1 edges.
//   gnt_done_i
//     - Ignored in ARB_IDLE: no state change, no ack.
//   Protocol violation (req_s falls while GRANTED)
//     - The grant is held until gnt_done_i.
//     - At that edge the channel returns to IDLE, ack_o stays 0, and proto_err_o pulses for 1 cycle.
//   Simultaneous events
//     - gnt_done_i and a new request arriving on the same edge: the new request is arbitrated next cycle.
//     - Several requests becoming pending together are resolved by the RR order.
//
// TESTING
//   1 Single request, S=2: req_i=4'b0001 before edge0
//     -> gnt_valid_o=1, gnt_idx_o=0 after edge2.
//     -> gnt_done_i pulse -> ack_o=4'b0001 next edge and gnt_valid_o=0.
//     -> req_i=0 -> ack_o=0 three edges later.
//   2 req_i=4'b1111 held, gnt_done_i 2 cycles after each grant
//     -> grants issued to idx 0,1,2,3 in order with >=1 idle cycle between them.
//     -> ack_o accumulates to 4'b1111; no second grant to any channel.
//   3 Fairness: last grant was idx 2; req 0 and req 3 become pending on the same edge
//     -> idx 3 granted first, then idx 0.
//   4 Withdrawal: drop req_i[1] while idx 1 is granted
//     -> gnt_valid_o stays 1 until gnt_done_i; then proto_err_o=1 for one cycle and ack_o[1]=0.
//     -> A stray gnt_done_i in ARB_IDLE has no effect.
//   5 Reset mid-grant: arst_ni=0 while gnt_valid_o=1
//     -> all outputs 0 immediately.
//     -> After release with req_i=4'b0110 held: idx 1 granted after 3 edges.
//   6 SYNC_MIDDLE_STAGE=1: repeat scenario 1
//     -> grant and ack release each occur one edge later (4 edges).

Source files
------------

// File: rtl/cdc_req_arbiter.sv
// Round-robin arbiter granting one clk_i-domain resource to NUM_REQ asynchronous
// requesters, each running a 4-phase req/ack handshake through a flop synchroniser.

module dual_flop_sync #(
    parameter int unsigned MIDDLE_STAGE_EN = 0
) (
    input  logic clk_i,
    input  logic arst_ni,
    input  logic d_i,
    output logic q_o
);

    localparam int unsigned STAGES = 2 + MIDDLE_STAGE_EN;

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

module cdc_req_arbiter #(
    parameter  int unsigned NUM_REQ           = 4,
    parameter  int unsigned SYNC_MIDDLE_STAGE = 0,
    localparam int unsigned IDX_W             = $clog2(NUM_REQ)
) (
    input  logic               clk_i,
    input  logic               arst_ni,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] ack_o,
    output logic               gnt_valid_o,
    output logic [IDX_W-1:0]   gnt_idx_o,
    input  logic               gnt_done_i,
    output logic               proto_err_o
);

    localparam logic [1:0] CH_IDLE    = 2'd0;
    localparam logic [1:0] CH_GRANTED = 2'd1;
    localparam logic [1:0] CH_ACKED   = 2'd2;

    localparam logic [0:0] ARB_IDLE = 1'b0;
    localparam logic [0:0] ARB_BUSY = 1'b1;

    logic [NUM_REQ-1:0] req_s;
    logic [NUM_REQ-1:0] pending;

    logic [1:0]         ch_q [NUM_REQ];
    logic [1:0]         ch_d [NUM_REQ];
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [0:0]         arb_q, arb_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
    logic               proto_err_q, proto_err_d;

    logic               found;
    logic [IDX_W-1:0]   win_idx;
    logic               grant_now;
    logic               done_now;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_sync
        dual_flop_sync #(
            .MIDDLE_STAGE_EN(SYNC_MIDDLE_STAGE)
        ) u_sync (
            .clk_i  (clk_i),
            .arst_ni(arst_ni),
            .d_i    (req_i[g]),
            .q_o    (req_s[g])
        );
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            pending[i] = req_s[i] && (ch_q[i] == CH_IDLE);
        end
    end

    // Search begins one past the last winner; offsets 1..NUM_REQ wrap back to last_q itself.
    always_comb begin
        int unsigned idx;
        found   = 1'b0;
        win_idx = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = 32'(last_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && pending[IDX_W'(idx)]) begin
                found   = 1'b1;
                win_idx = IDX_W'(idx);
            end
        end
    end

    always_comb begin
        arb_d     = arb_q;
        last_d    = last_q;
        gnt_idx_d = gnt_idx_q;
        grant_now = 1'b0;
        done_now  = 1'b0;
        case (arb_q)
            ARB_IDLE: begin
                if (found) begin
                    arb_d     = ARB_BUSY;
                    last_d    = win_idx;
                    gnt_idx_d = win_idx;
                    grant_now = 1'b1;
                end
            end
            default: begin
                if (gnt_done_i) begin
                    arb_d    = ARB_IDLE;
                    done_now = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        proto_err_d = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            ch_d[i] = ch_q[i];
            case (ch_q[i])
                CH_IDLE: begin
                    if (grant_now && (win_idx == IDX_W'(i))) begin
                        ch_d[i] = CH_GRANTED;
                    end
                end
                CH_GRANTED: begin
                    // Only one channel can be GRANTED, so done_now always belongs to it.
                    if (done_now) begin
                        if (req_s[i]) begin
                            ch_d[i] = CH_ACKED;
                        end else begin
                            ch_d[i]     = CH_IDLE;
                            proto_err_d = 1'b1;
                        end
                    end
                end
                CH_ACKED: begin
                    if (!req_s[i]) begin
                        ch_d[i] = CH_IDLE;
                    end
                end
                default: begin
                    ch_d[i] = CH_IDLE;
                end
            endcase
            ack_d[i] = (ch_d[i] == CH_ACKED);
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                ch_q[i] <= CH_IDLE;
            end
            ack_q       <= '0;
            arb_q       <= ARB_IDLE;
            last_q      <= IDX_W'(NUM_REQ - 1);
            gnt_idx_q   <= '0;
            proto_err_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                ch_q[i] <= ch_d[i];
            end
            ack_q       <= ack_d;
            arb_q       <= arb_d;
            last_q      <= last_d;
            gnt_idx_q   <= gnt_idx_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign ack_o       = ack_q;
    assign gnt_valid_o = (arb_q == ARB_BUSY);
    assign gnt_idx_o   = gnt_idx_q;
    assign proto_err_o = proto_err_q;

endmodule

// File: tb/tb_cdc_req_arbiter.sv
// Directed bench for cdc_req_arbiter: S=2 instance for the main scenarios and an
// S=3 instance for the extra synchroniser stage.

module tb_cdc_req_arbiter;

    logic       clk = 1'b0;
    logic       arst_ni = 1'b0;
    logic [3:0] req = '0;
    logic       gnt_done = 1'b0;
    logic [3:0] ack;
    logic       gnt_valid;
    logic [1:0] gnt_idx;
    logic       proto_err;

    logic [3:0] req3 = '0;
    logic       gnt_done3 = 1'b0;
    logic [3:0] ack3;
    logic       gnt_valid3;
    logic [1:0] gnt_idx3;
    logic       proto_err3;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    cdc_req_arbiter #(.NUM_REQ(4), .SYNC_MIDDLE_STAGE(0)) dut (
        .clk_i(clk), .arst_ni(arst_ni), .req_i(req), .ack_o(ack),
        .gnt_valid_o(gnt_valid), .gnt_idx_o(gnt_idx),
        .gnt_done_i(gnt_done), .proto_err_o(proto_err)
    );

    cdc_req_arbiter #(.NUM_REQ(4), .SYNC_MIDDLE_STAGE(1)) dut3 (
        .clk_i(clk), .arst_ni(arst_ni), .req_i(req3), .ack_o(ack3),
        .gnt_valid_o(gnt_valid3), .gnt_idx_o(gnt_idx3),
        .gnt_done_i(gnt_done3), .proto_err_o(proto_err3)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        arst_ni = 1'b0;
        #3;
        arst_ni = 1'b1;
    endtask

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (gnt_valid) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    task automatic pulse_done();
        gnt_done = 1'b1;
        tick(1);
        gnt_done = 1'b0;
    endtask

    task automatic test_reset();
        arst_ni = 1'b0;
        #2;
        tests_run++;
        if ({ack, gnt_valid, gnt_idx, proto_err} !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h expected 00", {ack, gnt_valid, gnt_idx, proto_err});
        end
        tests_run++;
        if ({ack3, gnt_valid3, gnt_idx3, proto_err3} !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_outputs_s3: got %h expected 00", {ack3, gnt_valid3, gnt_idx3, proto_err3});
        end
        tick(2);
        arst_ni = 1'b1;
        tick(3);
        tests_run++;
        if ({ack, gnt_valid, proto_err} !== 6'h00) begin
            tests_failed++;
            $display("FAIL idle_after_reset: got %h expected 00", {ack, gnt_valid, proto_err});
        end
    endtask

    task automatic test_single();
        req = 4'b0001;
        tick(2);
        tests_run++;
        if (gnt_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_no_early_grant: got %b expected 0", gnt_valid);
        end
        tick(1);
        tests_run++;
        if ({gnt_valid, gnt_idx} !== 3'b100) begin
            tests_failed++;
            $display("FAIL single_grant: got %b expected 100", {gnt_valid, gnt_idx});
        end
        pulse_done();
        tests_run++;
        if ({ack, gnt_valid} !== 5'b00010) begin
            tests_failed++;
            $display("FAIL single_ack: got %b expected 00010", {ack, gnt_valid});
        end
        req = 4'b0000;
        tick(2);
        tests_run++;
        if (ack !== 4'b0001) begin
            tests_failed++;
            $display("FAIL single_ack_held: got %b expected 0001", ack);
        end
        tick(1);
        tests_run++;
        if (ack !== 4'b0000) begin
            tests_failed++;
            $display("FAIL single_ack_release: got %b expected 0000", ack);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [3:0] exp_ack;
        do_reset();
        exp_ack = '0;
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            wait_grant(ok);
            tests_run++;
            if (!ok || gnt_idx !== 2'(k)) begin
                tests_failed++;
                $display("FAIL rr_grant_%0d: got valid=%b idx=%0d expected idx=%0d", k, ok, gnt_idx, k);
            end
            tick(1);
            pulse_done();
            exp_ack[k] = 1'b1;
            tests_run++;
            if ({ack, gnt_valid} !== {exp_ack, 1'b0}) begin
                tests_failed++;
                $display("FAIL rr_ack_gap_%0d: got %b expected %b", k, {ack, gnt_valid}, {exp_ack, 1'b0});
            end
        end
        tick(4);
        tests_run++;
        if ({ack, gnt_valid} !== 5'b11110) begin
            tests_failed++;
            $display("FAIL rr_no_regrant: got %b expected 11110", {ack, gnt_valid});
        end
        req = 4'b0000;
        tick(3);
        tests_run++;
        if (ack !== 4'b0000) begin
            tests_failed++;
            $display("FAIL rr_release: got %b expected 0000", ack);
        end
    endtask

    task automatic test_fairness();
        bit ok;
        req = 4'b0100;
        wait_grant(ok);
        tests_run++;
        if (!ok || gnt_idx !== 2'd2) begin
            tests_failed++;
            $display("FAIL fair_prime: got valid=%b idx=%0d expected idx=2", ok, gnt_idx);
        end
        pulse_done();
        req = 4'b0000;
        tick(4);
        req = 4'b1001;
        wait_grant(ok);
        tests_run++;
        if (!ok || gnt_idx !== 2'd3) begin
            tests_failed++;
            $display("FAIL fair_first: got valid=%b idx=%0d expected idx=3", ok, gnt_idx);
        end
        pulse_done();
        wait_grant(ok);
        tests_run++;
        if (!ok || gnt_idx !== 2'd0) begin
            tests_failed++;
            $display("FAIL fair_second: got valid=%b idx=%0d expected idx=0", ok, gnt_idx);
        end
        pulse_done();
        req = 4'b0000;
        tick(4);
        tests_run++;
        if ({ack, gnt_valid} !== 5'b00000) begin
            tests_failed++;
            $display("FAIL fair_cleanup: got %b expected 00000", {ack, gnt_valid});
        end
    endtask

    task automatic test_withdraw();
        bit ok;
        req = 4'b0010;
        wait_grant(ok);
        tests_run++;
        if (!ok || gnt_idx !== 2'd1) begin
            tests_failed++;
            $display("FAIL wd_grant: got valid=%b idx=%0d expected idx=1", ok, gnt_idx);
        end
        req = 4'b0000;
        tick(4);
        tests_run++;
        if ({gnt_valid, gnt_idx} !== 3'b101) begin
            tests_failed++;
            $display("FAIL wd_grant_held: got %b expected 101", {gnt_valid, gnt_idx});
        end
        pulse_done();
        tests_run++;
        if ({proto_err, ack, gnt_valid} !== 6'b100000) begin
            tests_failed++;
            $display("FAIL wd_proto_err: got %b expected 100000", {proto_err, ack, gnt_valid});
        end
        tick(1);
        tests_run++;
        if (proto_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL wd_err_one_cycle: got %b expected 0", proto_err);
        end
        pulse_done();
        tests_run++;
        if ({proto_err, ack, gnt_valid} !== 6'b000000) begin
            tests_failed++;
            $display("FAIL stray_done: got %b expected 000000", {proto_err, ack, gnt_valid});
        end
    endtask

    task automatic test_reset_mid_grant();
        bit ok;
        req = 4'b0110;
        wait_grant(ok);
        tests_run++;
        if (!ok || gnt_idx !== 2'd2) begin
            tests_failed++;
            $display("FAIL rst_pre_grant: got valid=%b idx=%0d expected idx=2", ok, gnt_idx);
        end
        #2 arst_ni = 1'b0;
        #1;
        tests_run++;
        if ({ack, gnt_valid, gnt_idx, proto_err} !== 8'h00) begin
            tests_failed++;
            $display("FAIL rst_async_clear: got %h expected 00", {ack, gnt_valid, gnt_idx, proto_err});
        end
        #1 arst_ni = 1'b1;
        tick(2);
        tests_run++;
        if (gnt_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_no_early_grant: got %b expected 0", gnt_valid);
        end
        tick(1);
        tests_run++;
        if ({gnt_valid, gnt_idx} !== 3'b101) begin
            tests_failed++;
            $display("FAIL rst_regrant: got %b expected 101", {gnt_valid, gnt_idx});
        end
        pulse_done();
        tests_run++;
        if ({ack, gnt_valid} !== 5'b00100) begin
            tests_failed++;
            $display("FAIL rst_ack1: got %b expected 00100", {ack, gnt_valid});
        end
        tick(1);
        tests_run++;
        if ({gnt_valid, gnt_idx} !== 3'b110) begin
            tests_failed++;
            $display("FAIL rst_next_grant: got %b expected 110", {gnt_valid, gnt_idx});
        end
        pulse_done();
        req = 4'b0000;
        tick(4);
        tests_run++;
        if ({ack, gnt_valid} !== 5'b00000) begin
            tests_failed++;
            $display("FAIL rst_cleanup: got %b expected 00000", {ack, gnt_valid});
        end
    endtask

    task automatic test_middle_stage();
        req3 = 4'b0001;
        tick(3);
        tests_run++;
        if (gnt_valid3 !== 1'b0) begin
            tests_failed++;
            $display("FAIL s3_no_early_grant: got %b expected 0", gnt_valid3);
        end
        tick(1);
        tests_run++;
        if ({gnt_valid3, gnt_idx3} !== 3'b100) begin
            tests_failed++;
            $display("FAIL s3_grant: got %b expected 100", {gnt_valid3, gnt_idx3});
        end
        gnt_done3 = 1'b1;
        tick(1);
        gnt_done3 = 1'b0;
        tests_run++;
        if ({ack3, gnt_valid3} !== 5'b00010) begin
            tests_failed++;
            $display("FAIL s3_ack: got %b expected 00010", {ack3, gnt_valid3});
        end
        req3 = 4'b0000;
        tick(3);
        tests_run++;
        if (ack3 !== 4'b0001) begin
            tests_failed++;
            $display("FAIL s3_ack_held: got %b expected 0001", ack3);
        end
        tick(1);
        tests_run++;
        if (ack3 !== 4'b0000) begin
            tests_failed++;
            $display("FAIL s3_ack_release: got %b expected 0000", ack3);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_fairness();
        test_withdraw();
        test_reset_mid_grant();
        test_middle_stage();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
